ps2_key_decoder: RTL
====================

# ps2_key_decoder

Receives PS/2 keyboard frames and decodes scan-code set 2 make/break sequences into held-key level signals for the player-movement FSM. It produces the six control levels the movement FSM consumes: up/left/down/right arrows, Z (jump) and X (shoot). It sits between the board PS/2 pins and the movement FSM, in the `Clk` domain.

## Interface
- `TIMEOUT_CYCLES`, default 50000: `Clk` cycles without a PS/2 falling edge before a partial frame is discarded (1 ms at 50 MHz).
- `Clk` input 1: system clock.
- `RESET` input 1: synchronous, active-high reset.
- `PS2_CLK` input 1: raw PS/2 clock, asynchronous.
- `PS2_DAT` input 1: raw PS/2 data, asynchronous.
- `up_arrow`, `left_arrow`, `down_arrow`, `right_arrow` output 1 each: arrow keys currently held.
- `z_jump_key`, `x_shoot_key` output 1 each: Z and X keys currently held.
- `keycode` output 8: last correctly framed byte.
- `keycode_valid` output 1: one-cycle pulse when `keycode` updates.
- `frame_err` output 1: one-cycle pulse when a frame is rejected.

## Operation
- `PS2_CLK` and `PS2_DAT` each pass through a 2-flop synchronizer. A falling edge is detected on the synced clock against a third registered copy.
- Frame FSM, which advances only on detected falling edges:
  - IDLE: the sampled bit must be 0 (start). Go to DATA with bit count 0. A sampled 1 stays in IDLE and raises no error.
  - DATA: shift in 8 bits LSB-first. After the 8th bit, go to PARITY.
  - PARITY: capture the bit. The 8 data bits plus the parity bit must contain an odd number of ones.
  - STOP: the sampled bit must be 1. If parity and stop are both good, load `keycode` and pulse `keycode_valid`. Otherwise pulse `frame_err`. Either way return to IDLE.
- Byte decoder, which acts on each `keycode_valid` byte:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - 0xE1 loads a skip counter with 7. The following 7 bytes (the Pause sequence) are ignored. The counter decrements per byte.
  - 0xFA and 0xAA are ignored. They do not clear the flags.
  - Any other byte is a final byte: look it up, then clear `ext` and `brk`.
- Lookup with `ext` = 1: 0x75 is up, 0x72 is down, 0x6B is left, 0x74 is right.
- Lookup with `ext` = 0: 0x1A is Z, 0x22 is X.
- A code matched with the wrong `ext` value has no effect; for example, a bare 0x75 (keypad 8) does not drive up.
- On a matched key, set its level if `brk` = 0 and clear it if `brk` = 1. Unmatched final bytes change nothing.
- `frame_err` clears `ext`, `brk` and the skip counter. Key levels are kept.
- Left and right may be high together. Conflict resolution belongs to the movement FSM.

## Timing
- Reset values: all key levels 0, `keycode` 0x00, `keycode_valid` 0, `frame_err` 0, FSM in IDLE, `ext`/`brk`/skip counter 0, synchronizer flops 1 (idle bus).
- Pin-to-edge latency: 3 `Clk` cycles from a `PS2_CLK` fall to the internal edge strobe.
- `keycode_valid` and `frame_err` are asserted in the cycle after the stop-bit edge strobe.
- Key levels change in the cycle after `keycode_valid`. Total latency is 2 cycles after the stop-bit strobe.
- `RESET` mid-frame: the frame is abandoned with no error pulse. It has priority over every other event in the same cycle.
- The skip counter saturates at 0.
- Consecutive frames need no gap. IDLE accepts a start bit on the very next edge strobe.

## Configuration
- Macro: `PS2_TIMEOUT_EN`.
- Defined: a 16-bit watchdog resets on every edge strobe and increments while the FSM is outside IDLE.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, `frame_err` pulses once and the prefix flags clear.
  - In IDLE the watchdog holds 0.
- Undefined: no watchdog logic. A truncated frame stays in progress until it is completed by further edges or ended by `RESET`. `TIMEOUT_CYCLES` is unused.

## Structure
- Package `ps2_pkg`:
  - frame-state enum (IDLE, DATA, PARITY, STOP);
  - scan-code constants: `SC_EXT` 0xE0, `SC_BRK` 0xF0, `SC_PAUSE` 0xE1, `SC_ACK` 0xFA, `SC_BAT` 0xAA, and the six key codes.
- Sub-module `ps2_frame_rx`: synchronizers, edge detect, frame FSM and watchdog. It outputs `keycode`, `keycode_valid` and `frame_err`.
- `ps2_key_decoder` instantiates `ps2_frame_rx` and holds the prefix flags, skip counter and key registers.

## Test plan
- Frame 0x1A (odd parity 0) → `keycode` = 0x1A, one `keycode_valid` pulse, `z_jump_key` rises 2 cycles after the stop strobe. Then F0 1A → `z_jump_key` falls.
- E0 74, then E0 6B → `right_arrow` and `left_arrow` both 1. Then E0 F0 74 → only `right_arrow` clears.
- Frame 0x22 with the parity bit flipped → `frame_err` pulse, no `keycode_valid`, `x_shoot_key` stays 0. A following good 0x22 sets `x_shoot_key`.
- E0 followed by a bare 75 in a separate sequence → `up_arrow` set by the first. Byte 75 without E0 → no change to `up_arrow`.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 1A → all arrows unchanged, `z_jump_key` = 1.
- `PS2_TIMEOUT_EN` defined, `TIMEOUT_CYCLES` = 100, 4 bits sent then the clock is stopped → `frame_err` pulse 100 cycles after the last strobe. A following good 0x22 decodes correctly. Assert `RESET` mid-frame → all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 keyboard decoder.
//   - frame_state_e : PS/2 frame receiver states
//   - key_levels_t  : the six held-key levels driven to the movement FSM
//   - SC_*          : scan-code set 2 prefix/control bytes and key codes
//   - odd_parity_ok : parity check helper for a received byte
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  typedef struct packed {
    logic up;
    logic left;
    logic down;
    logic right;
    logic z;
    logic x;
  } key_levels_t;

  // Prefix and control bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_ACK   = 8'hFA;
  localparam logic [7:0] SC_BAT   = 8'hAA;

  // Key codes (arrows are E0-extended, Z/X are plain)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_X     = 8'h22;

  // Bytes of the Pause sequence that follow its leading E1
  localparam logic [2:0] SKIP_PAUSE = 3'd7;

  // Data byte plus parity bit must carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_if
// Bundles the PS/2 pins and the decoded key outputs of ps2_key_decoder.
//   master : board/bench side - drives PS2_CLK/PS2_DAT, observes outputs
//   slave  : decoder side     - samples the pins, drives the outputs
// Signals:
//   PS2_CLK, PS2_DAT                 raw asynchronous PS/2 pins
//   up/left/down/right_arrow         arrow keys held
//   z_jump_key, x_shoot_key          Z / X held
//   keycode[7:0]                     last correctly framed byte
//   keycode_valid                    1-cycle pulse on keycode update
//   frame_err                        1-cycle pulse on rejected frame
// ---------------------------------------------------------------------------
interface ps2_key_decoder_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic       up_arrow;
  logic       left_arrow;
  logic       down_arrow;
  logic       right_arrow;
  logic       z_jump_key;
  logic       x_shoot_key;
  logic [7:0] keycode;
  logic       keycode_valid;
  logic       frame_err;

  modport master (
    output PS2_CLK, PS2_DAT,
    input  up_arrow, left_arrow, down_arrow, right_arrow,
    input  z_jump_key, x_shoot_key, keycode, keycode_valid, frame_err
  );

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output up_arrow, left_arrow, down_arrow, right_arrow,
    output z_jump_key, x_shoot_key, keycode, keycode_valid, frame_err
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// Synchronizes the raw PS/2 pins, detects falling edges of the PS/2 clock
// and assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop).
// Optional macro PS2_TIMEOUT_EN adds a watchdog that abandons a partial
// frame after TIMEOUT_CYCLES Clk cycles without an edge.
// Ports:
//   Clk, RESET         system clock, synchronous active-high reset
//   i_ps2_clk/i_ps2_dat raw asynchronous PS/2 pins
//   o_keycode[7:0]     last correctly framed byte
//   o_keycode_valid    1-cycle pulse when o_keycode updates
//   o_frame_err        1-cycle pulse when a frame is rejected
// ---------------------------------------------------------------------------
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       RESET,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_keycode,
  output logic       o_keycode_valid,
  output logic       o_frame_err
);
  import ps2_pkg::*;

  logic         r_clk_s1, r_clk_s2, r_clk_s3;
  logic         r_dat_s1, r_dat_s2;
  logic         r_fall;
  frame_state_e r_state, w_state_nxt;
  logic [2:0]   r_bit_cnt;
  logic [7:0]   r_shift;
  logic         r_par;
  logic [7:0]   r_keycode;
  logic         r_valid, r_err;
  logic         w_load, w_err;
  logic         w_timeout;

  // Two-flop synchronizers plus a third clock copy for edge detection.
  // Flops reset to 1 so an idle bus produces no spurious edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_fall   <= 1'b0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= i_ps2_dat;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= r_clk_s3 & ~r_clk_s2;
    end
  end

`ifdef PS2_TIMEOUT_EN
  // Watchdog: cleared on each edge strobe and while idle, counts otherwise.
  // A strobe in the same cycle wins over an expiring count.
  logic [15:0] r_wdog;

  always_ff @(posedge Clk) begin
    if (RESET) begin
      r_wdog <= '0;
    end else if (r_fall || w_timeout || (r_state == IDLE)) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 16'd1;
    end
  end

  assign w_timeout = (r_state != IDLE) && !r_fall &&
                     (r_wdog == 16'(TIMEOUT_CYCLES));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
`endif

  // Frame FSM: state register
  always_ff @(posedge Clk) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Frame FSM: next state, advancing only on edge strobes
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = IDLE;
    end else if (r_fall) begin
      case (r_state)
        IDLE:    if (!r_dat_s2) w_state_nxt = DATA;
        DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        PARITY:  w_state_nxt = STOP;
        STOP:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Frame FSM: outputs - accept or reject on the stop-bit strobe
  always_comb begin
    w_load = 1'b0;
    w_err  = w_timeout;
    if (r_fall && (r_state == STOP)) begin
      if (r_dat_s2 && odd_parity_ok(r_shift, r_par)) w_load = 1'b1;
      else                                            w_err  = 1'b1;
    end
  end

  // Datapath: shift register, bit counter, parity, output byte and pulses
  always_ff @(posedge Clk) begin
    if (RESET) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_keycode <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= w_load;
      r_err   <= w_err;
      if (w_load) r_keycode <= r_shift;
      if (r_fall) begin
        case (r_state)
          IDLE: r_bit_cnt <= '0;
          DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY:  r_par <= r_dat_s2;
          default: ;
        endcase
      end
    end
  end

  assign o_keycode       = r_keycode;
  assign o_keycode_valid = r_valid;
  assign o_frame_err     = r_err;

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Decodes scan-code set 2 make/break sequences into held-key levels for the
// player-movement FSM (arrows, Z = jump, X = shoot).
// Optional macro PS2_TIMEOUT_EN enables the partial-frame watchdog in
// ps2_frame_rx (TIMEOUT_CYCLES is unused otherwise).
// Ports:
//   Clk    system clock
//   RESET  synchronous active-high reset
//   bus    ps2_key_decoder_if.slave: PS/2 pins in, key levels, keycode,
//          keycode_valid and frame_err out
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic               Clk,
  input logic               RESET,
  ps2_key_decoder_if.slave  bus
);
  import ps2_pkg::*;

  logic [7:0]  w_keycode;
  logic        w_keycode_valid;
  logic        w_frame_err;

  logic        r_ext;
  logic        r_brk;
  logic [2:0]  r_skip;
  key_levels_t r_keys;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .Clk             (Clk),
    .RESET           (RESET),
    .i_ps2_clk       (bus.PS2_CLK),
    .i_ps2_dat       (bus.PS2_DAT),
    .o_keycode       (w_keycode),
    .o_keycode_valid (w_keycode_valid),
    .o_frame_err     (w_frame_err)
  );

  // Byte decoder. A rejected frame drops any pending prefix and Pause skip
  // but keeps the key levels, since the matching break may still arrive.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_skip <= '0;
      r_keys <= '0;
    end else if (w_frame_err) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_skip <= '0;
    end else if (w_keycode_valid) begin
      if (r_skip != 3'd0) begin
        // Inside the Pause sequence: swallow the byte, whatever it is
        r_skip <= r_skip - 3'd1;
      end else begin
        case (w_keycode)
          SC_EXT:         r_ext  <= 1'b1;
          SC_BRK:         r_brk  <= 1'b1;
          SC_PAUSE:       r_skip <= SKIP_PAUSE;
          SC_ACK, SC_BAT: ;  // keyboard status bytes leave prefixes intact
          default: begin
            // Final byte: a code only counts with its own ext setting
            if (r_ext) begin
              case (w_keycode)
                SC_UP:    r_keys.up    <= ~r_brk;
                SC_DOWN:  r_keys.down  <= ~r_brk;
                SC_LEFT:  r_keys.left  <= ~r_brk;
                SC_RIGHT: r_keys.right <= ~r_brk;
                default:  ;
              endcase
            end else begin
              case (w_keycode)
                SC_Z:    r_keys.z <= ~r_brk;
                SC_X:    r_keys.x <= ~r_brk;
                default: ;
              endcase
            end
            r_ext <= 1'b0;
            r_brk <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.up_arrow      = r_keys.up;
  assign bus.left_arrow    = r_keys.left;
  assign bus.down_arrow    = r_keys.down;
  assign bus.right_arrow   = r_keys.right;
  assign bus.z_jump_key    = r_keys.z;
  assign bus.x_shoot_key   = r_keys.x;
  assign bus.keycode       = w_keycode;
  assign bus.keycode_valid = w_keycode_valid;
  assign bus.frame_err     = w_frame_err;

endmodule
